sanity_ctrl: RTL and testbench
==============================

Name: sanity_ctrl

Overview:
- Single-clock controller for the DELQA sanity timer: arms, re-arms (host kick), counts down and fires the BDCOK reset pulse.
- Replaces derived-clock counting with clock-enable strobes on the 2.5 MHz board clock.
- Sits between the CSR/setup-packet decode (sanity code, enable, kick) and the Q-bus BDCOK driver.

Parameters:
- QSEC_DIV, 625000, board clocks per 1/4-second unit strobe.
- MIN_DIV, 240, 1/4-second strobes per 1-minute unit strobe.
- PULSE_LEN, 10000, clocks BDCOK is held low (4 ms at 2.5 MHz); must be >= 1.

Ports:
- clock  in  1  2.5 MHz board clock.
- rst  in  1  Reset; asynchronous, active-high.
- sanity  in  3  Timeout code. [2]=unit (0: 1/4 s, 1: 1 min); [1:0]=count (00:1, 01:4, 10:16, 11:64). Latched only at load.
- ena  in  1  Timer enable, level.
- kick  in  1  One-cycle host re-arm strobe.
- bdcok_n  out  1  1 = OK; 0 = reset pulse active.
- armed  out  1  1 while counting (ARMED state).
- expired  out  1  Sticky, set on pulse start.

Behaviour:
- Reset (async, immediate): state IDLE, bdcok_n=1, armed=0, expired=0, all counters 0.
- States are IDLE, ARMED, PULSE and HOLD.
- IDLE:
  - ena=1 sampled at edge -> ARMED.
  - Load cnt (7 bits) from sanity; latch unit bit.
  - Clear prescaler and minute divider.
  - Clear expired.
- ARMED:
  - Prescaler counts 0..QSEC_DIV-1 and emits qs strobe on wrap.
  - Minute divider counts qs strobes 0..MIN_DIV-1 and emits ms strobe on wrap.
  - Unit strobe = ms if latched unit=1, else qs. Each unit strobe decrements cnt.
  - Unit strobe with cnt==1 -> PULSE. bdcok_n=0 from that edge; expired=1.
  - Timeout = N*QSEC_DIV (1/4 s unit) or N*QSEC_DIV*MIN_DIV (minute unit) clocks after the load edge.
  - kick -> reload cnt from current sanity and clear both dividers (full interval restarts).
  - ena=0 -> IDLE.
- Priority in ARMED: ena=0 > kick > terminal strobe. Kick on the same cycle as the terminal strobe prevents expiry.
- PULSE:
  - Pulse counter runs PULSE_LEN cycles; bdcok_n=0 throughout. The pulse is never truncated by ena or kick.
  - On completion: bdcok_n=1 on the next edge. Go to IDLE if ena=0, else HOLD.
- HOLD:
  - bdcok_n=1; timer stays dormant.
  - kick -> reload, go to ARMED, expired cleared.
  - ena=0 -> IDLE.
- armed is a registered decode of state==ARMED.
- Width rules:
  - cnt is 7 bits, max 64; it never underflows (decrement gated by cnt!=0).
  - Divider widths = clog2 of their limits.
- sanity changes during ARMED have no effect until the next load (arm or kick).
- rst asserted mid-operation: outputs reach reset values asynchronously, including mid-pulse (bdcok_n -> 1).

Decomposition:
- Shared package holds:
  - State encoding (IDLE, ARMED, PULSE, HOLD).
  - The sanity-code-to-count constants (1, 4, 16, 64).
  - The clog2 function.
- One sub-module, sanity_tick_gen: prescaler plus minute divider.
  - Inputs: clear, run.
  - Outputs: qs and ms one-cycle strobes.
  - Async reset.

Test Plan (QSEC_DIV=4, MIN_DIV=3, PULSE_LEN=5; edge 0 = edge where ena first sampled 1):
- sanity=000, ena=1 -> bdcok_n falls at edge 4, low for 5 cycles, high at edge 9; expired=1; state HOLD, armed=0.
- sanity=011 -> bdcok_n falls at edge 256. sanity=101 (4 min units) -> falls at edge 48. sanity=111 -> falls at edge 768.
- sanity=000, kick every 3 clocks -> bdcok_n stays 1 indefinitely. Stop kicks (last at edge K) -> falls at edge K+4. Kick coincident with the terminal strobe -> no pulse.
- Drop ena at edge 2 of the pulse -> bdcok_n stays 0 for the full 5 cycles, then IDLE with armed=0. Re-raise ena -> new full interval, expired cleared.
- sanity changed 010->000 mid-ARMED -> expiry still at 16 units. Next kick reloads the new value (expiry 4 clocks after the kick edge).
- Async rst asserted mid-pulse, between edges -> bdcok_n=1, expired=0, armed=0 immediately without a clock edge. Release with ena=1 -> re-arm at the next edge.

Source files
------------

// File: rtl/sanity_pkg.sv
// Shared definitions for the DELQA sanity timer: state encoding, timeout-code
// decode and a width helper.
package sanity_pkg;

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StArmed = 2'd1,
      StPulse = 2'd2,
      StHold  = 2'd3
   } state_e;

   localparam logic [6:0] CntCode0 = 7'd1;
   localparam logic [6:0] CntCode1 = 7'd4;
   localparam logic [6:0] CntCode2 = 7'd16;
   localparam logic [6:0] CntCode3 = 7'd64;

   function automatic int unsigned clog2(input int unsigned v);
      int unsigned r;
      int unsigned x;
      r = 0;
      if (v > 1) begin
         x = v - 1;
         while (x > 0) begin
            r = r + 1;
            x = x >> 1;
         end
      end
      return r;
   endfunction

   function automatic logic [6:0] sanity_count(input logic [1:0] code);
      logic [6:0] c;
      case (code)
         2'b00:   c = CntCode0;
         2'b01:   c = CntCode1;
         2'b10:   c = CntCode2;
         default: c = CntCode3;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/sanity_tick_gen.sv
// Quarter-second prescaler and minute divider; emits one-cycle qs/ms strobes
// while run_i is high, both dividers return to zero on clear_i.
module sanity_tick_gen
   import sanity_pkg::*;
#(
   parameter int unsigned QSEC_DIV = 625000,
   parameter int unsigned MIN_DIV  = 240
) (
   input  logic clock_i,
   input  logic rst_i,
   input  logic clear_i,
   input  logic run_i,
   output logic qs_o,
   output logic ms_o
);

   localparam int unsigned PW = (QSEC_DIV > 1) ? clog2(QSEC_DIV) : 1;
   localparam int unsigned MW = (MIN_DIV > 1) ? clog2(MIN_DIV) : 1;

   logic [PW-1:0] presc_q, presc_d;
   logic [MW-1:0] mins_q, mins_d;
   logic          presc_wrap, mins_wrap;

   assign presc_wrap = (presc_q == PW'(QSEC_DIV - 1));
   assign mins_wrap  = (mins_q == MW'(MIN_DIV - 1));

   // Clear wins over run so a reload never leaks a stale strobe.
   assign qs_o = run_i && !clear_i && presc_wrap;
   assign ms_o = qs_o && mins_wrap;

   always_comb begin
      presc_d = presc_q;
      mins_d  = mins_q;
      if (clear_i) begin
         presc_d = '0;
         mins_d  = '0;
      end else if (run_i) begin
         presc_d = presc_wrap ? '0 : presc_q + 1'b1;
         if (qs_o) begin
            mins_d = mins_wrap ? '0 : mins_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clock_i or posedge rst_i) begin
      if (rst_i) begin
         presc_q <= '0;
         mins_q  <= '0;
      end else begin
         presc_q <= presc_d;
         mins_q  <= mins_d;
      end
   end

endmodule

// File: rtl/sanity_ctrl.sv
// DELQA sanity timer controller: arms, re-arms on host kick, counts down in
// quarter-second or minute units and drives the BDCOK reset pulse.
module sanity_ctrl
   import sanity_pkg::*;
#(
   parameter int unsigned QSEC_DIV  = 625000,
   parameter int unsigned MIN_DIV   = 240,
   parameter int unsigned PULSE_LEN = 10000
) (
   input  logic       clock,
   input  logic       rst,
   input  logic [2:0] sanity,
   input  logic       ena,
   input  logic       kick,
   output logic       bdcok_n,
   output logic       armed,
   output logic       expired
);

   localparam int unsigned LW = (PULSE_LEN > 1) ? clog2(PULSE_LEN) : 1;

   state_e        state_q, state_d;
   logic [6:0]    cnt_q, cnt_d;
   logic          unit_q, unit_d;
   logic [LW-1:0] pcnt_q, pcnt_d;
   logic          bdcok_n_q, bdcok_n_d;
   logic          armed_q, armed_d;
   logic          expired_q, expired_d;

   logic tick_clr, tick_run, qs, ms, unit_stb;

   sanity_tick_gen #(
      .QSEC_DIV (QSEC_DIV),
      .MIN_DIV  (MIN_DIV)
   ) u_tick_gen (
      .clock_i (clock),
      .rst_i   (rst),
      .clear_i (tick_clr),
      .run_i   (tick_run),
      .qs_o    (qs),
      .ms_o    (ms)
   );

   assign tick_run = (state_q == StArmed);
   assign unit_stb = unit_q ? ms : qs;

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      unit_d    = unit_q;
      pcnt_d    = pcnt_q;
      bdcok_n_d = bdcok_n_q;
      expired_d = expired_q;
      tick_clr  = 1'b0;

      case (state_q)
         StIdle: begin
            if (ena) begin
               state_d   = StArmed;
               cnt_d     = sanity_count(sanity[1:0]);
               unit_d    = sanity[2];
               tick_clr  = 1'b1;
               expired_d = 1'b0;
            end
         end
         StArmed: begin
            if (!ena) begin
               state_d = StIdle;
            end else if (kick) begin
               cnt_d    = sanity_count(sanity[1:0]);
               unit_d   = sanity[2];
               tick_clr = 1'b1;
            end else if (unit_stb && cnt_q != 7'd0) begin
               cnt_d = cnt_q - 7'd1;
               if (cnt_q == 7'd1) begin
                  state_d   = StPulse;
                  pcnt_d    = '0;
                  bdcok_n_d = 1'b0;
                  expired_d = 1'b1;
               end
            end
         end
         StPulse: begin
            // The pulse always runs to completion; ena only picks the exit.
            if (pcnt_q == LW'(PULSE_LEN - 1)) begin
               pcnt_d    = '0;
               bdcok_n_d = 1'b1;
               state_d   = ena ? StHold : StIdle;
            end else begin
               pcnt_d = pcnt_q + 1'b1;
            end
         end
         StHold: begin
            if (!ena) begin
               state_d = StIdle;
            end else if (kick) begin
               state_d   = StArmed;
               cnt_d     = sanity_count(sanity[1:0]);
               unit_d    = sanity[2];
               tick_clr  = 1'b1;
               expired_d = 1'b0;
            end
         end
         default: state_d = StIdle;
      endcase

      armed_d = (state_d == StArmed);
   end

   always_ff @(posedge clock or posedge rst) begin
      if (rst) begin
         state_q   <= StIdle;
         cnt_q     <= '0;
         unit_q    <= 1'b0;
         pcnt_q    <= '0;
         bdcok_n_q <= 1'b1;
         armed_q   <= 1'b0;
         expired_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         unit_q    <= unit_d;
         pcnt_q    <= pcnt_d;
         bdcok_n_q <= bdcok_n_d;
         armed_q   <= armed_d;
         expired_q <= expired_d;
      end
   end

   assign bdcok_n = bdcok_n_q;
   assign armed   = armed_q;
   assign expired = expired_q;

endmodule

// File: tb/tb_sanity_ctrl.sv
// Self-checking bench for sanity_ctrl with small divider values so every
// timeout code can be walked to expiry.
module tb_sanity_ctrl;

   localparam int unsigned QS = 4;
   localparam int unsigned MD = 3;
   localparam int unsigned PL = 5;

   logic       clock = 1'b0;
   logic       rst = 1'b0;
   logic [2:0] sanity = 3'b000;
   logic       ena = 1'b0;
   logic       kick = 1'b0;
   logic       bdcok_n, armed, expired;

   int total = 0;
   int bad = 0;

   typedef struct {
      logic [2:0] code;
      int         fall;
   } vec_t;

   vec_t vecs[8];

   sanity_ctrl #(
      .QSEC_DIV  (QS),
      .MIN_DIV   (MD),
      .PULSE_LEN (PL)
   ) dut (
      .clock   (clock),
      .rst     (rst),
      .sanity  (sanity),
      .ena     (ena),
      .kick    (kick),
      .bdcok_n (bdcok_n),
      .armed   (armed),
      .expired (expired)
   );

   always #5 clock = ~clock;

   task automatic chk(input string name, input int act, input int req);
      total++;
      if (act != req) begin
         bad++;
         $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, req, $time);
      end
   endtask

   task automatic chk_bit(input string name, input logic act, input logic req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %b, want %b (t=%0t)", name, act, req, $time);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic do_reset();
      rst  = 1'b1;
      ena  = 1'b0;
      kick = 1'b0;
      step();
      step();
      rst = 1'b0;
   endtask

   // Sets the code and ena; the edge consumed here is edge 0.
   task automatic arm(input logic [2:0] s);
      sanity = s;
      ena    = 1'b1;
      step();
   endtask

   task automatic kick_once();
      kick = 1'b1;
      step();
      kick = 1'b0;
   endtask

   task automatic wait_level(input logic lvl, input int maxn, output int n);
      n = -1;
      for (int i = 1; i <= maxn; i++) begin
         step();
         if (bdcok_n === lvl) begin
            n = i;
            break;
         end
      end
   endtask

   initial begin
      int n;
      logic saw_low;

      vecs[0] = '{3'b000, 4};
      vecs[1] = '{3'b001, 16};
      vecs[2] = '{3'b010, 64};
      vecs[3] = '{3'b011, 256};
      vecs[4] = '{3'b100, 12};
      vecs[5] = '{3'b101, 48};
      vecs[6] = '{3'b110, 192};
      vecs[7] = '{3'b111, 768};

      #1 rst = 1'b1;
      #1;
      chk_bit("reset bdcok_n", bdcok_n, 1'b1);
      chk_bit("reset armed", armed, 1'b0);
      chk_bit("reset expired", expired, 1'b0);
      step();
      rst = 1'b0;

      // Every timeout code: expiry edge, pulse width, HOLD afterwards.
      for (int i = 0; i < 8; i++) begin
         do_reset();
         arm(vecs[i].code);
         chk_bit("armed after load", armed, 1'b1);
         chk_bit("bdcok_n after load", bdcok_n, 1'b1);
         wait_level(1'b0, vecs[i].fall + 20, n);
         chk($sformatf("fall edge code=%b", vecs[i].code), n, vecs[i].fall);
         chk_bit("expired at pulse", expired, 1'b1);
         chk_bit("armed at pulse", armed, 1'b0);
         wait_level(1'b1, PL + 5, n);
         chk("pulse length", n, PL);
         chk_bit("armed in hold", armed, 1'b0);
         chk_bit("expired in hold", expired, 1'b1);
         step();
         chk_bit("hold stays high", bdcok_n, 1'b1);
         ena = 1'b0;
         step();
      end

      // Kicks every 3 clocks keep the timer alive; then 4 clocks to expiry.
      do_reset();
      arm(3'b000);
      saw_low = 1'b0;
      for (int i = 0; i < 10; i++) begin
         step();
         saw_low |= ~bdcok_n;
         step();
         saw_low |= ~bdcok_n;
         kick_once();
         saw_low |= ~bdcok_n;
      end
      chk_bit("kicked never fires", saw_low, 1'b0);
      chk_bit("kicked still armed", armed, 1'b1);
      wait_level(1'b0, 20, n);
      chk("fall after last kick", n, 4);
      wait_level(1'b1, PL + 5, n);

      // Kick on the terminal strobe edge prevents expiry.
      do_reset();
      arm(3'b000);
      step();
      step();
      step();
      kick_once();
      chk_bit("coincident kick bdcok_n", bdcok_n, 1'b1);
      chk_bit("coincident kick expired", expired, 1'b0);
      chk_bit("coincident kick armed", armed, 1'b1);
      wait_level(1'b0, 20, n);
      chk("fall after coincident kick", n, 4);

      // ena dropped mid-pulse: pulse completes, then IDLE.
      step();
      ena = 1'b0;
      chk_bit("pulse low at edge 1", bdcok_n, 1'b0);
      wait_level(1'b1, PL + 5, n);
      chk("pulse not truncated", n, PL - 1);
      chk_bit("idle armed", armed, 1'b0);
      chk_bit("idle keeps expired", expired, 1'b1);
      step();
      step();
      chk_bit("idle bdcok_n", bdcok_n, 1'b1);
      ena = 1'b1;
      step();
      chk_bit("rearm from idle", armed, 1'b1);
      chk_bit("rearm clears expired", expired, 1'b0);
      wait_level(1'b0, 20, n);
      chk("fall after rearm", n, 4);
      wait_level(1'b1, PL + 5, n);

      // sanity change mid-ARMED is ignored until the next load.
      do_reset();
      arm(3'b010);
      for (int i = 0; i < 10; i++) step();
      sanity = 3'b000;
      wait_level(1'b0, 80, n);
      chk("latched code expiry", n, 54);
      wait_level(1'b1, PL + 5, n);
      chk_bit("hold before kick", armed, 1'b0);
      kick_once();
      chk_bit("hold kick arms", armed, 1'b1);
      chk_bit("hold kick clears expired", expired, 1'b0);
      wait_level(1'b0, 20, n);
      chk("new code after kick", n, 4);

      // Async reset between edges, mid-pulse.
      step();
      #2 rst = 1'b1;
      #1;
      chk_bit("async rst bdcok_n", bdcok_n, 1'b1);
      chk_bit("async rst expired", expired, 1'b0);
      chk_bit("async rst armed", armed, 1'b0);
      #2 rst = 1'b0;
      step();
      chk_bit("rearm after rst", armed, 1'b1);
      wait_level(1'b0, 20, n);
      chk("fall after rst rearm", n, 4);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
